alu_operand_sequencer: RTL and testbench

Sits directly upstream of the 16-bit ALU and consumes its result. Holds an 8-entry x 16-bit register file and a 4-bit status register {C,Z,S,V}. Accepts one command per valid/ready handshake, drives the ALU's ABUS/BBUS/FSEL/CIN from registered operands, then captures FOUT and the flags. It writes the result and flags back and returns a one-cycle response. Completes the datapath loop for the microsequencer.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the operand sequencer and its register file.
//   DW          - datapath width, fixed to match the 16-bit ALU buses
//   FS_*        - ALU function-select encodings (FS_RSVD is the reserved code)
//   alu_state_e - sequencer FSM states
//   FLAG_*      - bit positions of {C,Z,S,V} inside the status register
package alu_pkg;

  localparam int DW = 16;

  localparam logic [3:0] FS_PASS  = 4'b0000;
  localparam logic [3:0] FS_INC   = 4'b0001;
  localparam logic [3:0] FS_DEC   = 4'b0010;
  localparam logic [3:0] FS_ADD   = 4'b0011;
  localparam logic [3:0] FS_SUB   = 4'b0100;
  localparam logic [3:0] FS_AND   = 4'b0101;
  localparam logic [3:0] FS_OR    = 4'b0110;
  localparam logic [3:0] FS_XOR   = 4'b0111;
  localparam logic [3:0] FS_NOT   = 4'b1000;
  localparam logic [3:0] FS_SHL   = 4'b1001;
  localparam logic [3:0] FS_SHR   = 4'b1010;
  localparam logic [3:0] FS_ASR   = 4'b1011;
  localparam logic [3:0] FS_ROL   = 4'b1100;
  localparam logic [3:0] FS_ROR   = 4'b1101;
  localparam logic [3:0] FS_BSWAP = 4'b1110;
  localparam logic [3:0] FS_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } alu_state_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_rsvd(input logic [3:0] fsel);
    return fsel == FS_RSVD;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DW register file, asynchronously cleared.
//   clk_i, rst_ni          - clock, async active-low clear
//   we_i/waddr_i/wdata_i   - single write port (arbitrated by the parent)
//   raddr_a_i/rdata_a_o    - combinational read port A
//   raddr_b_i/rdata_b_o    - combinational read port B
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: feeds registered operands to the external 16-bit ALU,
// captures its result and flags, writes them back and returns a response.
//   CLK, RST_N                      - clock, async active-low reset
//   CMD_*                           - command channel (valid/ready)
//   LD_*                            - direct register load channel (valid/ready)
//   ABUS, BBUS, FSEL, CIN           - registered ALU inputs
//   FOUT, ALU_C/Z/S/V               - combinational ALU result and flags
//   RSP_VALID, RSP_DATA, RSP_ERR    - one-cycle response
//   STATUS                          - stored flags {C,Z,S,V}
//   DBG_STATE                       - current FSM state for observation
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high. Ready does not depend on the same channel's valid. A requester
// that is not accepted must hold valid and its payload until it is.
// Both channels are only ready in IDLE; a load beats a command in the same
// cycle, so a blocked command simply stays pending.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [3:0]    CMD_FSEL,
  input  logic [AW-1:0] CMD_RA,
  input  logic [AW-1:0] CMD_RB,
  input  logic [AW-1:0] CMD_RD,
  input  logic          CMD_WE,
  input  logic          CMD_FLAGS_WE,
  input  logic          CMD_USEC,
  input  logic          LD_VALID,
  output logic          LD_READY,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic [DW-1:0] ABUS,
  output logic [DW-1:0] BBUS,
  output logic [3:0]    FSEL,
  output logic          CIN,
  input  logic [DW-1:0] FOUT,
  input  logic          ALU_C,
  input  logic          ALU_Z,
  input  logic          ALU_S,
  input  logic          ALU_V,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_ERR,
  output logic [3:0]    STATUS,
  output logic [1:0]    DBG_STATE
);

  alu_state_e state_q, state_d;
  logic       cmd_accept, ld_accept;

  logic [DW-1:0] abus_q, bbus_q, res_q;
  logic [3:0]    fsel_q, status_q, flags_q;
  logic          cin_q, we_q, fwe_q, err_q;
  logic [AW-1:0] rd_q;
  logic          rsp_valid_q, rsp_err_q;

  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic          rf_we, wb_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    LD_READY   = (state_q == IDLE);
    CMD_READY  = (state_q == IDLE) && !LD_VALID;
    ld_accept  = LD_VALID && LD_READY;
    cmd_accept = CMD_VALID && CMD_READY;
    DBG_STATE  = state_q;
  end

  // Operand latch at accept, result capture at end of EXEC, writeback at end of WB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      abus_q      <= '0;
      bbus_q      <= '0;
      fsel_q      <= '0;
      cin_q       <= 1'b0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      fwe_q       <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      status_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (cmd_accept) begin
        abus_q <= rf_rdata_a;
        bbus_q <= rf_rdata_b;
        fsel_q <= CMD_FSEL;
        cin_q  <= CMD_USEC ? status_q[FLAG_C] : 1'b0;
        rd_q   <= CMD_RD;
        we_q   <= CMD_WE;
        fwe_q  <= CMD_FLAGS_WE;
        err_q  <= is_rsvd(CMD_FSEL);
      end
      if (state_q == EXEC) begin
        // A reserved function returns zero; its flags are never committed.
        res_q   <= err_q ? '0 : FOUT;
        flags_q <= {ALU_C, ALU_Z, ALU_S, ALU_V};
      end
      if (state_q == WB && fwe_q && !err_q) status_q <= flags_q;
      rsp_valid_q <= (state_q == EXEC);
      rsp_err_q   <= (state_q == EXEC) && err_q;
    end
  end

  // Loads only happen in IDLE and writeback only in WB, so they never collide.
  assign wb_write = (state_q == WB) && we_q && !err_q;
  assign rf_we    = ld_accept || wb_write;
  assign rf_waddr = ld_accept ? LD_ADDR : rd_q;
  assign rf_wdata = ld_accept ? LD_DATA : res_q;

  alu_regfile #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_regfile (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr_a_i(CMD_RA),
    .rdata_a_o(rf_rdata_a),
    .raddr_b_i(CMD_RB),
    .rdata_b_o(rf_rdata_b)
  );

  assign ABUS      = abus_q;
  assign BBUS      = bbus_q;
  assign FSEL      = fsel_q;
  assign CIN       = cin_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = res_q;
  assign RSP_ERR   = rsp_err_q;
  assign STATUS    = status_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed, table-driven bench for the operand
// sequencer, with a small behavioural model of the external ALU.
module tb_alu_operand_sequencer;

  logic        CLK, RST_N;
  logic        CMD_VALID, CMD_READY;
  logic [3:0]  CMD_FSEL;
  logic [2:0]  CMD_RA, CMD_RB, CMD_RD;
  logic        CMD_WE, CMD_FLAGS_WE, CMD_USEC;
  logic        LD_VALID, LD_READY;
  logic [2:0]  LD_ADDR;
  logic [15:0] LD_DATA;
  logic [15:0] ABUS, BBUS;
  logic [3:0]  FSEL;
  logic        CIN;
  logic [15:0] FOUT;
  logic        ALU_C, ALU_Z, ALU_S, ALU_V;
  logic        RSP_VALID, RSP_ERR;
  logic [15:0] RSP_DATA;
  logic [3:0]  STATUS;
  logic [1:0]  DBG_STATE;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  alu_operand_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FSEL(CMD_FSEL),
    .CMD_RA(CMD_RA), .CMD_RB(CMD_RB), .CMD_RD(CMD_RD),
    .CMD_WE(CMD_WE), .CMD_FLAGS_WE(CMD_FLAGS_WE), .CMD_USEC(CMD_USEC),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .ABUS(ABUS), .BBUS(BBUS), .FSEL(FSEL), .CIN(CIN),
    .FOUT(FOUT), .ALU_C(ALU_C), .ALU_Z(ALU_Z), .ALU_S(ALU_S), .ALU_V(ALU_V),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .STATUS(STATUS), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- ALU model ----------------
  logic [16:0] sum;
  always_comb begin
    sum   = '0;
    FOUT  = ABUS;
    ALU_C = 1'b0;
    ALU_V = 1'b0;
    case (FSEL)
      4'b0001: begin
        sum   = {1'b0, ABUS} + 17'd1;
        FOUT  = sum[15:0];
        ALU_C = sum[16];
        ALU_V = (ABUS == 16'h7FFF);
      end
      4'b0011: begin
        sum   = {1'b0, ABUS} + {1'b0, BBUS} + {16'd0, CIN};
        FOUT  = sum[15:0];
        ALU_C = sum[16];
        ALU_V = (ABUS[15] == BBUS[15]) && (sum[15] != ABUS[15]);
      end
      4'b1111: begin
        FOUT  = 16'hDEAD;
        ALU_C = 1'b1;
        ALU_V = 1'b1;
      end
      default: FOUT = ABUS;
    endcase
    ALU_Z = (FOUT == 16'h0000);
    ALU_S = FOUT[15];
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
    bit ok = 0;
    LD_ADDR  = addr;
    LD_DATA  = data;
    LD_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (LD_READY) begin ok = 1; break; end
    end
    if (!ok) check("load_timeout", 0, 1);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
  endtask

  // Returns #1 after the accepting edge (first EXEC cycle).
  task automatic issue_cmd(input logic [3:0] fs, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input logic we, input logic fwe,
                           input logic usec);
    bit ok = 0;
    CMD_FSEL = fs; CMD_RA = ra; CMD_RB = rb; CMD_RD = rd;
    CMD_WE = we; CMD_FLAGS_WE = fwe; CMD_USEC = usec;
    CMD_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  fsel;
    logic [2:0]  ra, rb, rd;
    logic        we, fwe, usec;
    logic [15:0] abus, bbus;
    logic        cin;
    logic [15:0] data;
    logic        err;
    logic [3:0]  status;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [3:0] fs, input logic [2:0] ra, input logic [2:0] rb,
                              input logic [2:0] rd, input logic we, input logic fwe,
                              input logic usec, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic [15:0] d, input logic err,
                              input logic [3:0] st);
    vec_t v;
    v.fsel = fs; v.ra = ra; v.rb = rb; v.rd = rd; v.we = we; v.fwe = fwe; v.usec = usec;
    v.abus = a; v.bbus = b; v.cin = cin; v.data = d; v.err = err; v.status = st;
    return v;
  endfunction

  logic [15:0] first_data;
  int          gap;

  initial begin
    // ADD 7FFF+1: overflow into sign -> C0 Z0 S1 V1
    vecs[0] = mk(4'b0011, 3'd1, 3'd2, 3'd3, 1, 1, 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 4'b0011);
    // PASS R3 to observe the writeback
    vecs[1] = mk(4'b0000, 3'd3, 3'd0, 3'd6, 0, 0, 0, 16'h8000, 16'h0000, 0, 16'h8000, 0, 4'b0011);
    // INC FFFF -> 0000, C1 Z1
    vecs[2] = mk(4'b0001, 3'd4, 3'd0, 3'd4, 1, 1, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 4'b1100);
    // ADD R0+R0 with stored carry
    vecs[3] = mk(4'b0011, 3'd0, 3'd0, 3'd5, 1, 0, 1, 16'h0000, 16'h0000, 1, 16'h0001, 0, 4'b1100);
    vecs[4] = mk(4'b0000, 3'd5, 3'd0, 3'd6, 0, 0, 0, 16'h0001, 16'h0000, 0, 16'h0001, 0, 4'b1100);
    // reserved function: zero result, error, no writes
    vecs[5] = mk(4'b1111, 3'd1, 3'd2, 3'd1, 1, 1, 0, 16'h7FFF, 16'h0001, 0, 16'h0000, 1, 4'b1100);
    vecs[6] = mk(4'b0000, 3'd1, 3'd0, 3'd6, 0, 0, 0, 16'h7FFF, 16'h0000, 0, 16'h7FFF, 0, 4'b1100);
    vecs[7] = mk(4'b0000, 3'd4, 3'd0, 3'd6, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 4'b1100);

    RST_N = 1'b0; CMD_VALID = 0; LD_VALID = 0; LD_ADDR = 0; LD_DATA = 0;
    CMD_FSEL = 0; CMD_RA = 0; CMD_RB = 0; CMD_RD = 0; CMD_WE = 0; CMD_FLAGS_WE = 0; CMD_USEC = 0;
    #2;
    check("rst_state", DBG_STATE, 0);
    check("rst_outputs", {ABUS, BBUS, FSEL, CIN}, 0);
    check("rst_rsp", {RSP_VALID, RSP_ERR, RSP_DATA}, 0);
    check("rst_status", STATUS, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    check("idle_ready", {CMD_READY, LD_READY}, 2'b11);

    do_load(3'd1, 16'h7FFF);
    do_load(3'd2, 16'h0001);
    do_load(3'd4, 16'hFFFF);

    for (int i = 0; i < 8; i++) begin
      issue_cmd(vecs[i].fsel, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].we, vecs[i].fwe,
                vecs[i].usec);
      check($sformatf("v%0d_abus", i), ABUS, vecs[i].abus);
      check($sformatf("v%0d_bbus", i), BBUS, vecs[i].bbus);
      check($sformatf("v%0d_fsel_cin", i), {FSEL, CIN}, {vecs[i].fsel, vecs[i].cin});
      check($sformatf("v%0d_exec_novalid", i), RSP_VALID, 0);
      exp_q.push_back(vecs[i].data);
      @(posedge CLK); #1;
      check($sformatf("v%0d_rsp_valid", i), RSP_VALID, 1);
      check($sformatf("v%0d_rsp_err", i), RSP_ERR, vecs[i].err);
      check($sformatf("v%0d_rsp_data", i), RSP_DATA, exp_q.pop_front());
      @(posedge CLK); #1;
      check($sformatf("v%0d_rsp_drop", i), {RSP_VALID, RSP_ERR}, 0);
      check($sformatf("v%0d_status", i), STATUS, vecs[i].status);
    end

    // Back-to-back INC R1->R1 with CMD_VALID held: second accept at N+3.
    issue_cmd(4'b0001, 3'd1, 3'd0, 3'd1, 1, 1, 0);
    CMD_VALID  = 1'b1;
    first_data = 16'h0;
    gap        = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (RSP_VALID) first_data = RSP_DATA;
      if (CMD_READY) begin
        @(posedge CLK); #1;
        gap = i;
        break;
      end
      @(posedge CLK);
    end
    CMD_VALID = 1'b0;
    check("b2b_gap", gap, 3);
    check("b2b_first", first_data, 16'h8000);
    @(posedge CLK); #1;
    check("b2b_second_valid", RSP_VALID, 1);
    check("b2b_second", RSP_DATA, first_data + 16'd1);
    @(posedge CLK); #1;
    check("b2b_status", STATUS, 4'b0010);

    // Load and command together in IDLE: load first, command next cycle.
    CMD_FSEL = 4'b0000; CMD_RA = 3'd6; CMD_RB = 3'd0; CMD_RD = 3'd7;
    CMD_WE = 0; CMD_FLAGS_WE = 0; CMD_USEC = 0;
    LD_ADDR = 3'd6; LD_DATA = 16'h1234;
    LD_VALID = 1'b1; CMD_VALID = 1'b1;
    @(negedge CLK);
    check("ldcmd_ready", {LD_READY, CMD_READY}, 2'b10);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
    @(negedge CLK);
    check("ldcmd_cmd_ready", CMD_READY, 1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    check("ldcmd_abus", ABUS, 16'h1234);
    @(posedge CLK); #1;
    check("ldcmd_rsp", {RSP_VALID, RSP_DATA}, {1'b1, 16'h1234});
    @(posedge CLK); #1;

    // Load during EXEC must be ignored.
    issue_cmd(4'b0000, 3'd6, 3'd0, 3'd7, 0, 0, 0);
    LD_ADDR = 3'd6; LD_DATA = 16'h5555; LD_VALID = 1'b1;
    @(negedge CLK);
    check("ld_exec_ready", LD_READY, 0);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
    @(posedge CLK); #1;
    issue_cmd(4'b0000, 3'd6, 3'd0, 3'd7, 0, 0, 0);
    check("ld_exec_ignored", ABUS, 16'h1234);
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset during EXEC aborts the operation.
    issue_cmd(4'b0001, 3'd2, 3'd0, 3'd7, 1, 1, 0);
    #3;
    RST_N = 1'b0;
    #1;
    check("mid_rst_bus", {ABUS, BBUS, FSEL, CIN}, 0);
    check("mid_rst_rsp", {RSP_VALID, RSP_ERR, RSP_DATA}, 0);
    check("mid_rst_status_state", {STATUS, DBG_STATE}, 0);
    @(negedge CLK); RST_N = 1'b1;
    gap = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RSP_VALID) gap++;
    end
    check("post_rst_no_rsp", gap, 0);
    check("post_rst_idle", {DBG_STATE, CMD_READY, STATUS}, {2'd0, 1'b1, 4'd0});
    issue_cmd(4'b0000, 3'd7, 3'd2, 3'd0, 0, 0, 0);
    check("post_rst_rd_unchanged", ABUS, 16'h0000);
    check("post_rst_rf_cleared", BBUS, 16'h0000);
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
